// File: rtl/uart_text_writer.sv
// uart_text_writer: 8N1 UART receiver feeding a cursor engine that writes
// printable ASCII into a COLS x ROWS character RAM read by the text display.
// Handles carriage return, backspace, line wrap and screen wrap (no scroll).
// Optional build macro: TEXT_CLEAR_EN -- after reset, sweep 0x20 into every
// cell before accepting any received byte.
module uart_text_writer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              frame_err,
    output logic              clearing
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CELLS   = COLS * ROWS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    rx_state_t         rx_state;
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              start_det;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        tick_num;
    logic [2:0]        bit_idx;
    logic [7:0]        byte_p0;
    logic              vld_p0;
    logic [7:0]        byte_p1;
    logic              vld_p1;
    logic              clr_active;
    logic [ADDR_W-1:0] clr_addr;

    // Linear cell address of a (col,row) position.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] c, input logic [4:0] r);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    // Row after a line break; the screen wraps to the top instead of scrolling.
    function automatic logic [4:0] next_row(input logic [4:0] r);
        return (r == 5'(ROWS - 1)) ? 5'd0 : r + 5'd1;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign start_det = (rx_state == S_IDLE) && rx_prev && !rx_sync;
    assign tick      = (tick_cnt == TICK_W'(DIV - 1));

    // Two-flop synchroniser for the asynchronous line, plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Oversample tick divider; re-phased at every start edge so samples land mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Stage p0: receive FSM, producing a one-cycle byte-valid or frame-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= S_IDLE;
            tick_num  <= '0;
            bit_idx   <= '0;
            byte_p0   <= '0;
            vld_p0    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vld_p0    <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (start_det) begin
                        rx_state <= S_START;
                        tick_num <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tick_num == 4'd7) begin
                            // Mid start bit: a line back high means it was a glitch.
                            tick_num <= '0;
                            bit_idx  <= '0;
                            rx_state <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            tick_num <= tick_num + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        tick_num <= tick_num + 4'd1;
                        if (tick_num == 4'd15) begin
                            byte_p0 <= {rx_sync, byte_p0[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                rx_state <= S_STOP;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        tick_num <= tick_num + 4'd1;
                        if (tick_num == 4'd15) begin
                            // A low stop bit drops the byte; IDLE then needs a fresh 1->0 edge.
                            rx_state <= S_IDLE;
                            if (rx_sync) begin
                                vld_p0 <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: byte handed to the cursor engine (control valid is reset, data is not).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1 data capture.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            byte_p1 <= byte_p0;
        end
    end

`ifdef TEXT_CLEAR_EN
    // Power-on sweep address generator; clearing stays high through the last write's cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_active <= 1'b1;
            clr_addr   <= '0;
            clearing   <= 1'b1;
        end else begin
            clearing <= clr_active;
            if (clr_active) begin
                if (clr_addr == ADDR_W'(CELLS - 1)) begin
                    clr_active <= 1'b0;
                end else begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                end
            end
        end
    end
`else
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
    assign clearing   = 1'b0;
`endif

    // Stage p2: cursor engine and registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clr_active) begin
                wr_en   <= 1'b1;
                wr_addr <= clr_addr;
                wr_data <= 7'h20;
            end else if (vld_p1 && !clearing) begin
                if (is_printable(byte_p1)) begin
                    wr_en   <= 1'b1;
                    wr_addr <= cell_addr(cursor_col, cursor_row);
                    wr_data <= byte_p1[6:0];
                    if (cursor_col == 7'(COLS - 1)) begin
                        cursor_col <= '0;
                        cursor_row <= next_row(cursor_row);
                    end else begin
                        cursor_col <= cursor_col + 7'd1;
                    end
                end else if (byte_p1 == 8'h0D) begin
                    cursor_col <= '0;
                    cursor_row <= next_row(cursor_row);
                end else if ((byte_p1 == 8'h08) && (cursor_col != 7'd0)) begin
                    wr_en      <= 1'b1;
                    wr_addr    <= cell_addr(cursor_col - 7'd1, cursor_row);
                    wr_data    <= 7'h20;
                    cursor_col <= cursor_col - 7'd1;
                end
            end
        end
    end

endmodule
